instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns a field bundle into a 32-bit word behind a
// single-register valid/ready stage, tagging each word with its byte address.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd_addr,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        out_err,
   output logic [7:0]  err_count
);

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_addr_q,  out_addr_d;
   logic        out_err_q,   out_err_d;
   logic [7:0]  err_count_q, err_count_d;
   logic [31:0] addr_cnt_q,  addr_cnt_d;

   logic signed [31:0] imm_s;
   logic [31:0]        enc_word;
   logic               enc_err;
   logic               in_fire;
   logic               out_fire;

   assign imm_s = imm;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      enc_word = 32'h0;
      enc_err  = 1'b0;
      case (fmt_e'(fmt))
         FMT_R: enc_word = {funct7, rs2_addr, rs1_addr, funct3, rd_addr, opcode};
         FMT_I: begin
            enc_word = {imm[11:0], rs1_addr, funct3, rd_addr, opcode};
            enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         end
         FMT_S: begin
            enc_word = {imm[11:5], rs2_addr, rs1_addr, funct3, imm[4:0], opcode};
            enc_err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         end
         FMT_B: begin
            enc_word = {imm[12], imm[10:5], rs2_addr, rs1_addr, funct3,
                        imm[4:1], imm[11], opcode};
            enc_err  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
         end
         FMT_U: begin
            enc_word = {imm[31:12], rd_addr, opcode};
            enc_err  = (imm[11:0] != 12'h000);
         end
         FMT_J: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd_addr, opcode};
            enc_err  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
         end
         default: enc_err = 1'b1;
      endcase
   end

   assign in_ready = !rst && (!out_valid_q || out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   always_comb begin
      // A word accepted alongside an output transfer takes the advanced address.
      addr_cnt_d  = out_fire ? addr_cnt_q + 32'd4 : addr_cnt_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_addr_d  = out_addr_q;
      out_err_d   = out_err_q;
      err_count_d = err_count_q;
      if (out_fire) begin
         out_valid_d = 1'b0;
      end
      if (in_fire) begin
         out_valid_d = 1'b1;
         out_instr_d = enc_err ? NOP_WORD : enc_word;
         out_addr_d  = addr_cnt_d;
         out_err_d   = enc_err;
         if (enc_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0;
         out_addr_q  <= BASE_ADDR;
         out_err_q   <= 1'b0;
         err_count_q <= 8'h00;
         addr_cnt_q  <= BASE_ADDR;
      end else begin
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_addr_q  <= out_addr_d;
         out_err_q   <= out_err_d;
         err_count_q <= err_count_d;
         addr_cnt_q  <= addr_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_addr  = out_addr_q;
   assign out_err   = out_err_q;
   assign err_count = err_count_q;

endmodule
